// File: rtl/proj_fm_reader.sv
// ---------------------------------------------------------------------------
// proj_fm_reader
// Read side of the FM buffer. A start pulse begins a sweep of every address
// 0..FM_BUFFER_SIZE-1 of a memory with 1-cycle read latency. The returned
// words are streamed out over a valid/ready interface, and the word from the
// last address carries a last flag. A 2-entry FIFO soaks up downstream
// backpressure so that no read already in flight is ever dropped.
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   start       one-cycle pulse that begins a sweep (ignored unless idle)
//   busy        high while reads are being issued or drained
//   rd_en       memory read strobe
//   rd_addr     memory read address, meaningful while rd_en=1
//   rd_data     memory data, valid the cycle after rd_en
//   out_data    head of the output FIFO
//   out_valid   out_data is valid
//   out_ready   downstream accepts out_data this cycle
//   out_last    out_data is the word from address FM_BUFFER_SIZE-1
//   done        one-cycle pulse after the final word is accepted
// ---------------------------------------------------------------------------
module proj_fm_reader #(
   parameter int FM_BUFFER_SIZE = 8,
   parameter int DATA_WIDTH     = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic                      busy,
   output logic                      rd_en,
   output logic [FM_BUFFER_SIZE-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0]     rd_data,
   output logic [DATA_WIDTH-1:0]     out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_last,
   output logic                      done
);

   localparam int AW = FM_BUFFER_SIZE;
   localparam logic [AW-1:0] LAST_ADDR = AW'(FM_BUFFER_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t                state_q;
   logic [AW-1:0]         cnt_q;
   logic                  busy_q;
   logic                  done_q;

   // Read issued last cycle: its data arrives on rd_data this cycle.
   logic                  inflight_q;
   logic                  inflight_last_q;

   // Two-entry FIFO; slot 0 is always the head.
   logic [1:0]            occ_q;
   logic [DATA_WIDTH-1:0] data0_q, data1_q;
   logic                  last0_q, last1_q;

   logic                  push;
   logic                  pop;
   logic [2:0]            level;
   logic                  issue_ok;
   logic [1:0]            occ_d;

   assign push = inflight_q;
   assign pop  = out_valid && out_ready;

   // Words that will occupy the FIFO after this cycle if nothing new is issued.
   // A new read is allowed only if its data is guaranteed a free slot.
   assign level    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue_ok = (level < 3'd2);
   assign occ_d    = occ_q + {1'b0, push} - {1'b0, pop};

   assign rd_en     = (state_q == READ) && issue_ok;
   assign rd_addr   = cnt_q;
   assign out_valid = (occ_q != 2'd0);
   assign out_data  = data0_q;
   assign out_last  = out_valid && last0_q;
   assign busy      = busy_q;
   assign done      = done_q;

   // Sweep control
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= READ;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            READ: begin
               if (rd_en) begin
                  // Counter parks on the last address rather than wrapping.
                  if (cnt_q == LAST_ADDR) begin
                     state_q <= DRAIN;
                  end else begin
                     cnt_q <= cnt_q + AW'(1);
                  end
               end
            end
            DRAIN: begin
               // No reads issue here, so an empty FIFO after this cycle
               // means the final word has just been accepted.
               if (occ_d == 2'd0) begin
                  state_q <= FINISH;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            FINISH: begin
               // Extra cycle keeps a start that coincides with done from
               // being accepted.
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Read pipeline and output FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         occ_q           <= 2'd0;
         data0_q         <= '0;
         data1_q         <= '0;
         last0_q         <= 1'b0;
         last1_q         <= 1'b0;
      end else begin
         inflight_q      <= rd_en;
         inflight_last_q <= rd_en && (cnt_q == LAST_ADDR);
         occ_q           <= occ_d;
         case ({push, pop})
            2'b10: begin
               if (occ_q == 2'd0) begin
                  data0_q <= rd_data;
                  last0_q <= inflight_last_q;
               end else begin
                  data1_q <= rd_data;
                  last1_q <= inflight_last_q;
               end
            end
            2'b01: begin
               data0_q <= data1_q;
               last0_q <= last1_q;
            end
            2'b11: begin
               if (occ_q == 2'd1) begin
                  data0_q <= rd_data;
                  last0_q <= inflight_last_q;
               end else begin
                  data0_q <= data1_q;
                  last0_q <= last1_q;
                  data1_q <= rd_data;
                  last1_q <= inflight_last_q;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_proj_fm_reader.sv
module tb_proj_fm_reader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        busy;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic [31:0] rd_data;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        done;

   proj_fm_reader #(.FM_BUFFER_SIZE(8), .DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory with 1-cycle read latency: word = 0x100 + address.
   always @(posedge clk) begin
      if (rd_en) rd_data <= 32'h100 + {24'd0, rd_addr};
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Downstream ready driver: 0 = always ready, 1 = random, 2 = stall window.
   int mode = 0;
   int t0   = 1000000;
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = !(cyc >= t0 + 4 && cyc <= t0 + 9);
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Scoreboard and protocol monitor
   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } exp_t;
   exp_t sb_q[$];

   logic        mon_en = 1'b0;
   logic        stall_prev = 1'b0;
   logic [31:0] prev_data;
   logic        prev_last;
   int          n_rd = 0, n_pop = 0, n_last = 0, n_done = 0;
   exp_t        mon_e;

   always @(negedge clk) begin
      if (mon_en) begin
         if (rd_en) begin
            check("rd_addr", 64'(rd_addr), 64'(n_rd));
            n_rd++;
         end
         if (stall_prev) begin
            check("stall_hold", {31'd0, out_valid, prev_data, out_last},
                  {31'd0, 1'b1, out_data, prev_last});
         end
         if (mode == 2 && cyc == t0 + 6) begin
            check("stall_word", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h101});
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_word", 64'(out_data), 64'hDEAD);
            end else begin
               mon_e = sb_q.pop_front();
               check("word", {31'd0, out_data, out_last}, {31'd0, mon_e.data, mon_e.last});
            end
            n_pop++;
            if (out_last) n_last++;
         end
         if (done) n_done++;
         stall_prev = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic expect_sweep();
      n_rd = 0; n_pop = 0; n_last = 0; n_done = 0;
      for (int a = 0; a < 8; a++) sb_q.push_back({32'h100 + 32'(a), (a == 7)});
   endtask

   task automatic sweep_stats(input string nm);
      check({nm, "_reads"}, 64'(n_rd), 64'd8);
      check({nm, "_lasts"}, 64'(n_last), 64'd1);
      check({nm, "_dones"}, 64'(n_done), 64'd1);
      check({nm, "_sb_left"}, 64'(sb_q.size()), 64'd0);
   endtask

   // One sweep; extra_at > 0 pulses start again at cycle T+extra_at.
   task automatic run_sweep(input string nm, input int extra_at);
      int k;
      expect_sweep();
      @(posedge clk); #1 start = 1'b1; t0 = cyc;
      @(posedge clk); #1 start = 1'b0;
      if (extra_at > 0) begin
         repeat (extra_at - 1) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      k = 0;
      while (n_done == 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (n_done == 0) check({nm, "_done_timeout"}, 64'd0, 64'd1);
      repeat (4) @(negedge clk);
      sweep_stats(nm);
   endtask

   typedef struct {
      logic        rd_en;
      logic [7:0]  addr;
      logic        valid;
      logic [31:0] data;
      logic        last;
      logic        done;
      logic        busy_care;
      logic        busy;
   } vec_t;
   vec_t tbl[12];

   initial begin
      int k;
      // Expected cycle-by-cycle outputs for offsets T+1..T+12, out_ready=1.
      for (int i = 0; i < 12; i++) begin
         int off;
         off = i + 1;
         tbl[i].rd_en     = (off <= 8);
         tbl[i].addr      = (off <= 8) ? 8'(off - 1) : 8'd0;
         tbl[i].valid     = (off >= 3 && off <= 10);
         tbl[i].data      = (off >= 3 && off <= 10) ? 32'h100 + 32'(off - 3) : 32'd0;
         tbl[i].last      = (off == 10);
         tbl[i].done      = (off == 11);
         tbl[i].busy_care = (off <= 10) || (off == 12);
         tbl[i].busy      = (off <= 10);
      end

      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle", {60'd0, busy, rd_en, out_valid, done}, 64'd0);
      end

      // Nominal sweep against the latency table
      mon_en = 1'b1;
      mode   = 0;
      expect_sweep();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         check($sformatf("vec_T+%0d", i + 1),
               {rd_en, (rd_en ? rd_addr : 8'd0), out_valid, (out_valid ? out_data : 32'd0),
                out_last, done, 20'd0},
               {tbl[i].rd_en, tbl[i].addr, tbl[i].valid, tbl[i].data,
                tbl[i].last, tbl[i].done, 20'd0});
         if (tbl[i].busy_care) check($sformatf("busy_T+%0d", i + 1), 64'(busy), 64'(tbl[i].busy));
      end
      // start coinciding with done (T+11) must be ignored
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("start_at_done_T+12", {62'd0, busy, rd_en}, {62'd0, tbl[11].busy, tbl[11].rd_en});
      @(negedge clk);
      check("start_at_done_T+13", {62'd0, busy, rd_en}, 64'd0);
      repeat (2) @(negedge clk);
      sweep_stats("nominal");

      // Backpressure window T+4..T+9
      mode = 2;
      run_sweep("stall", 0);
      mode = 0;
      t0   = 1000000;

      // Random backpressure
      mode = 1;
      for (int s = 0; s < 20; s++) run_sweep($sformatf("rand%0d", s), 0);
      mode = 0;

      // start while busy
      run_sweep("start_busy", 4);

      // Asynchronous reset mid-sweep
      expect_sweep();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      k = 0;
      while (n_pop < 3 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("pre_reset_words", 64'(n_pop), 64'd3);
      check("pre_reset_done", 64'(n_done), 64'd0);
      @(posedge clk); #3;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("async_reset_outputs",
            {busy, rd_en, rd_addr, out_valid, out_last, done, out_data},
            '0);
      @(negedge clk);
      check("reset_hold_done", {62'd0, done, busy}, 64'd0);
      rst_n = 1'b1;
      sb_q.delete();
      stall_prev = 1'b0;
      mon_en = 1'b1;
      run_sweep("after_reset", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
